// File: rtl/coherence_bus_agent_pkg.sv
// Shared types for the coherence bus agent: request kinds, block word offset
// and the initiator / snoop responder state encodings.
package coherence_bus_agent_pkg;

  localparam int OFF_BIT_DEF = 2;

  typedef enum logic [1:0] {
    FILL_S = 2'd0,
    FILL_M = 2'd1,
    WB     = 2'd2
  } req_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    W0,
    W1,
    DONE
  } init_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_PUSH0,
    S_PUSH1,
    S_FIN
  } snp_state_e;

  function automatic logic kind_legal(input logic [1:0] kind);
    return kind != 2'd3;
  endfunction

endpackage

// File: rtl/coherence_bus_agent_snoop_responder.sv
// Snoop responder: answers controller snoops, pushes dirty blocks
// cache-to-cache and issues downgrade / invalidate commands to the tag array.
module snoop_responder
  import coherence_bus_agent_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ccwait_i,
  input  logic              ccinv_i,
  input  logic              snp_hit_i,
  input  logic              snp_dirty_i,
  input  logic [WORD_W-1:0] snp_data0_i,
  input  logic [WORD_W-1:0] snp_data1_i,
  input  logic              wb_hit_i,
  input  logic [WORD_W-1:0] wb_data0_i,
  input  logic [WORD_W-1:0] wb_data1_i,
  output logic              busy_o,
  output logic              cctrans_o,
  output logic              ccwrite_o,
  output logic [WORD_W-1:0] dstore_o,
  output logic              snp_downgrade_o,
  output logic              snp_inval_o
);

  snp_state_e        state_q, state_d;
  logic              tag_hit_q, push_q, inv_q;
  logic [WORD_W-1:0] data0_q, data1_q;
  logic              eff_dirty;

  // A pending writeback of the snooped block counts as a dirty hit even
  // when the tag array has already dropped the line.
  assign eff_dirty = wb_hit_i | (snp_hit_i & snp_dirty_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      tag_hit_q <= 1'b0;
      push_q    <= 1'b0;
      inv_q     <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ccwait_i && (state_q == S_IDLE || state_q == S_SNOOP)) begin
        tag_hit_q <= snp_hit_i;
        push_q    <= eff_dirty;
        data0_q   <= wb_hit_i ? wb_data0_i : snp_data0_i;
        data1_q   <= wb_hit_i ? wb_data1_i : snp_data1_i;
      end
      unique case (state_q)
        S_IDLE:           inv_q <= ccwait_i & ccinv_i;
        S_SNOOP:          inv_q <= inv_q | (ccwait_i & ccinv_i);
        S_PUSH0, S_PUSH1: inv_q <= inv_q | ccinv_i;
        default:          inv_q <= inv_q;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ccwait_i) state_d = S_SNOOP;
      S_SNOOP: if (!ccwait_i) state_d = push_q ? S_PUSH0 : S_FIN;
      S_PUSH0: state_d = S_PUSH1;
      S_PUSH1: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o          = (state_q != S_IDLE);
    cctrans_o       = 1'b0;
    ccwrite_o       = 1'b0;
    dstore_o        = '0;
    snp_downgrade_o = 1'b0;
    snp_inval_o     = 1'b0;
    unique case (state_q)
      S_SNOOP: begin
        cctrans_o = ccwait_i & eff_dirty;
        ccwrite_o = ccwait_i & eff_dirty;
      end
      S_PUSH0: begin
        cctrans_o = 1'b1;
        ccwrite_o = 1'b1;
        dstore_o  = data0_q;
      end
      S_PUSH1: begin
        cctrans_o = 1'b1;
        ccwrite_o = 1'b1;
        dstore_o  = data1_q;
      end
      S_FIN: begin
        snp_inval_o     = tag_hit_q & inv_q;
        snp_downgrade_o = tag_hit_q & ~inv_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/coherence_bus_agent.sv
// Cache-side coherence bus agent: initiator FSM for two-word fills and
// writebacks, plus the priority mux that lets the snoop responder own the bus.
module coherence_bus_agent
  import coherence_bus_agent_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int OFF_BIT = OFF_BIT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic [1:0]        req_kind,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata0,
  input  logic [WORD_W-1:0] req_wdata1,
  output logic              req_done,
  output logic [WORD_W-1:0] fill_data0,
  output logic [WORD_W-1:0] fill_data1,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic              cctrans,
  output logic              ccwrite,
  input  logic              dwait,
  input  logic [WORD_W-1:0] dload,
  input  logic              ccwait,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic [WORD_W-1:0] snp_addr,
  input  logic              snp_hit,
  input  logic              snp_dirty,
  input  logic [WORD_W-1:0] snp_data0,
  input  logic [WORD_W-1:0] snp_data1,
  output logic              snp_downgrade,
  output logic              snp_inval
);

  localparam logic [WORD_W-1:0] OFF_MASK = {{(WORD_W-1){1'b0}}, 1'b1} << OFF_BIT;

  init_state_e       state_q, state_d;
  req_kind_e         kind_q;
  logic [WORD_W-1:0] addr_q, wdata0_q, wdata1_q;
  logic [WORD_W-1:0] fill0_q, fill1_q;
  logic              start, is_fill, wb_hit;

  logic              i_dren, i_dwen, i_cctrans, i_ccwrite;
  logic [WORD_W-1:0] i_daddr, i_dstore;
  logic              r_busy, r_cctrans, r_ccwrite;
  logic [WORD_W-1:0] r_dstore;

  assign start   = req_valid && kind_legal(req_kind);
  assign is_fill = (kind_q != WB);
  assign wb_hit  = (state_q == W0 || state_q == W1) && (kind_q == WB) &&
                   ((ccsnoopaddr & ~OFF_MASK) == addr_q);

  // The fill words are architectural outputs, so they are cleared on reset
  // along with the control state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      kind_q   <= FILL_S;
      addr_q   <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      fill0_q  <= '0;
      fill1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        kind_q   <= req_kind_e'(req_kind);
        addr_q   <= req_addr & ~OFF_MASK;
        wdata0_q <= req_wdata0;
        wdata1_q <= req_wdata1;
      end
      if (state_q == W0 && !dwait && is_fill) fill0_q <= dload;
      if (state_q == W1 && !dwait && is_fill) fill1_q <= dload;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = W0;
      W0:      if (!dwait) state_d = W1;
      W1:      if (!dwait) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_dren    = 1'b0;
    i_dwen    = 1'b0;
    i_daddr   = '0;
    i_dstore  = '0;
    i_cctrans = 1'b0;
    i_ccwrite = 1'b0;
    req_done  = 1'b0;
    unique case (state_q)
      W0, W1: begin
        i_daddr   = (state_q == W1) ? (addr_q | OFF_MASK) : addr_q;
        i_cctrans = 1'b1;
        i_ccwrite = (kind_q == FILL_M);
        i_dren    = is_fill;
        i_dwen    = !is_fill;
        if (!is_fill) i_dstore = (state_q == W1) ? wdata1_q : wdata0_q;
      end
      DONE:    req_done = 1'b1;
      default: ;
    endcase
  end

  snoop_responder #(.WORD_W(WORD_W)) u_snoop (
    .CLK             (CLK),
    .RST             (RST),
    .ccwait_i        (ccwait),
    .ccinv_i         (ccinv),
    .snp_hit_i       (snp_hit),
    .snp_dirty_i     (snp_dirty),
    .snp_data0_i     (snp_data0),
    .snp_data1_i     (snp_data1),
    .wb_hit_i        (wb_hit),
    .wb_data0_i      (wdata0_q),
    .wb_data1_i      (wdata1_q),
    .busy_o          (r_busy),
    .cctrans_o       (r_cctrans),
    .ccwrite_o       (r_ccwrite),
    .dstore_o        (r_dstore),
    .snp_downgrade_o (snp_downgrade),
    .snp_inval_o     (snp_inval)
  );

  // While snooped, the responder owns the coherence flags and data bus; a
  // pending request keeps dREN/dWEN up since the controller will not grant it.
  assign cctrans    = r_busy ? r_cctrans : i_cctrans;
  assign ccwrite    = r_busy ? r_ccwrite : i_ccwrite;
  assign dstore     = r_busy ? r_dstore  : i_dstore;
  assign dREN       = i_dren;
  assign dWEN       = i_dwen;
  assign daddr      = i_daddr;
  assign snp_addr   = ccsnoopaddr;
  assign fill_data0 = fill0_q;
  assign fill_data1 = fill1_q;

endmodule

// File: tb/tb_coherence_bus_agent.sv
// Directed bench for coherence_bus_agent: fills, writebacks, snoops,
// writeback-buffer hits and mid-transaction reset.
module tb_coherence_bus_agent;

  logic        CLK, RST;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [31:0] req_addr, req_wdata0, req_wdata1;
  logic        req_done;
  logic [31:0] fill_data0, fill_data1;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic        cctrans, ccwrite;
  logic        dwait;
  logic [31:0] dload;
  logic        ccwait, ccinv;
  logic [31:0] ccsnoopaddr, snp_addr;
  logic        snp_hit, snp_dirty;
  logic [31:0] snp_data0, snp_data1;
  logic        snp_downgrade, snp_inval;

  int checks   = 0;
  int failures = 0;

  coherence_bus_agent dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_kind(req_kind), .req_addr(req_addr),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_done(req_done), .fill_data0(fill_data0), .fill_data1(fill_data1),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .snp_addr(snp_addr), .snp_hit(snp_hit), .snp_dirty(snp_dirty),
    .snp_data0(snp_data0), .snp_data1(snp_data1),
    .snp_downgrade(snp_downgrade), .snp_inval(snp_inval)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".dREN"}, dREN, 0);
    check({tag, ".dWEN"}, dWEN, 0);
    check({tag, ".cctrans"}, cctrans, 0);
    check({tag, ".ccwrite"}, ccwrite, 0);
    check({tag, ".daddr"}, daddr, 0);
    check({tag, ".dstore"}, dstore, 0);
    check({tag, ".req_done"}, req_done, 0);
    check({tag, ".downgrade"}, snp_downgrade, 0);
    check({tag, ".inval"}, snp_inval, 0);
  endtask

  initial begin
    RST = 1'b1; req_valid = 0; req_kind = 0; req_addr = 0;
    req_wdata0 = 0; req_wdata1 = 0; dwait = 1; dload = 0;
    ccwait = 0; ccinv = 0; ccsnoopaddr = 0; snp_hit = 0; snp_dirty = 0;
    snp_data0 = 0; snp_data1 = 0;
    settle();
    check_quiet("reset");
    check("reset.fill0", fill_data0, 0);
    check("reset.fill1", fill_data1, 0);
    next(); RST = 1'b0; settle();

    // ---- FILL_S at 0x100, dwait low on cycles 3 and 5 ----
    next(); req_valid = 1; req_kind = 2'd0; req_addr = 32'h100; settle();
    check("fs.c1.dREN", dREN, 0);
    next(); dwait = 1; settle();
    check("fs.c2.dREN", dREN, 1);
    check("fs.c2.daddr", daddr, 32'h100);
    check("fs.c2.cctrans", cctrans, 1);
    check("fs.c2.ccwrite", ccwrite, 0);
    check("fs.c2.dWEN", dWEN, 0);
    next(); dwait = 0; dload = 32'hAAAA; settle();
    check("fs.c3.daddr", daddr, 32'h100);
    check("fs.c3.done", req_done, 0);
    next(); dwait = 1; dload = 0; settle();
    check("fs.c4.daddr", daddr, 32'h104);
    check("fs.c4.fill0", fill_data0, 32'hAAAA);
    next(); dwait = 0; dload = 32'hBBBB; settle();
    check("fs.c5.daddr", daddr, 32'h104);
    check("fs.c5.done", req_done, 0);
    next(); dwait = 1; dload = 0; settle();
    check("fs.c6.done", req_done, 1);
    check("fs.c6.dREN", dREN, 0);
    check("fs.c6.fill0", fill_data0, 32'hAAAA);
    check("fs.c6.fill1", fill_data1, 32'hBBBB);
    next(); req_valid = 0; settle();
    check("fs.c7.done", req_done, 0);
    check("fs.c7.fill1", fill_data1, 32'hBBBB);

    // ---- WB at 0x200, dwait low immediately ----
    next(); req_valid = 1; req_kind = 2'd2; req_addr = 32'h200;
    req_wdata0 = 32'h11; req_wdata1 = 32'h22; dwait = 0; settle();
    check("wb.c1.dWEN", dWEN, 0);
    next(); settle();
    check("wb.c2.dWEN", dWEN, 1);
    check("wb.c2.dREN", dREN, 0);
    check("wb.c2.daddr", daddr, 32'h200);
    check("wb.c2.dstore", dstore, 32'h11);
    check("wb.c2.cctrans", cctrans, 1);
    check("wb.c2.ccwrite", ccwrite, 0);
    next(); settle();
    check("wb.c3.daddr", daddr, 32'h204);
    check("wb.c3.dstore", dstore, 32'h22);
    check("wb.c3.done", req_done, 0);
    next(); settle();
    check("wb.c4.done", req_done, 1);
    check("wb.c4.dWEN", dWEN, 0);
    check("wb.c4.fill0_kept", fill_data0, 32'hAAAA);
    next(); req_valid = 0; dwait = 1; settle();
    check_quiet("wb.c5");

    // ---- illegal kind 3 is ignored ----
    next(); req_valid = 1; req_kind = 2'd3; req_addr = 32'h900; dwait = 1; settle();
    next(); settle();
    check("ill.dREN", dREN, 0);
    check("ill.dWEN", dWEN, 0);
    check("ill.cctrans", cctrans, 0);
    next(); req_valid = 0; settle();

    // ---- dirty-hit snoop of 0x300 with ccinv ----
    next(); ccwait = 1; ccinv = 1; ccsnoopaddr = 32'h300; snp_hit = 1; snp_dirty = 1;
    snp_data0 = 32'hD0D0; snp_data1 = 32'hD1D1; settle();
    check("sd.c1.snp_addr", snp_addr, 32'h300);
    next(); ccinv = 0; settle();
    check("sd.c2.cctrans", cctrans, 1);
    check("sd.c2.ccwrite", ccwrite, 1);
    next(); ccwait = 0; snp_hit = 0; snp_dirty = 0; snp_data0 = 0; snp_data1 = 0; settle();
    check("sd.c3.cctrans", cctrans, 0);
    next(); settle();
    check("sd.c4.dstore", dstore, 32'hD0D0);
    next(); settle();
    check("sd.c5.dstore", dstore, 32'hD1D1);
    check("sd.c5.inval", snp_inval, 0);
    next(); settle();
    check("sd.c6.inval", snp_inval, 1);
    check("sd.c6.downgrade", snp_downgrade, 0);
    next(); settle();
    check_quiet("sd.c7");

    // ---- clean-hit snoop, no ccinv ----
    next(); ccwait = 1; ccsnoopaddr = 32'h340; snp_hit = 1; snp_dirty = 0;
    snp_data0 = 32'hC0; snp_data1 = 32'hC1; settle();
    next(); settle();
    check("sc.c2.cctrans", cctrans, 0);
    check("sc.c2.ccwrite", ccwrite, 0);
    next(); ccwait = 0; snp_hit = 0; settle();
    check("sc.c3.downgrade", snp_downgrade, 0);
    check("sc.c3.dstore", dstore, 0);
    next(); settle();
    check("sc.c4.downgrade", snp_downgrade, 1);
    check("sc.c4.inval", snp_inval, 0);
    check("sc.c4.dstore", dstore, 0);
    next(); settle();
    check("sc.c5.downgrade", snp_downgrade, 0);

    // ---- WB at 0x400 snooped while held in W0: buffer supplies data ----
    next(); req_valid = 1; req_kind = 2'd2; req_addr = 32'h400;
    req_wdata0 = 32'h55; req_wdata1 = 32'h66; dwait = 1; settle();
    next(); ccwait = 1; ccsnoopaddr = 32'h400; snp_hit = 0; snp_dirty = 0;
    snp_data0 = 32'hEE; snp_data1 = 32'hEF; settle();
    check("wbh.c2.dWEN", dWEN, 1);
    next(); settle();
    check("wbh.c3.cctrans", cctrans, 1);
    check("wbh.c3.ccwrite", ccwrite, 1);
    check("wbh.c3.dWEN", dWEN, 1);
    next(); ccwait = 0; settle();
    next(); settle();
    check("wbh.c5.dstore", dstore, 32'h55);
    check("wbh.c5.dWEN", dWEN, 1);
    check("wbh.c5.daddr", daddr, 32'h400);
    next(); settle();
    check("wbh.c6.dstore", dstore, 32'h66);
    next(); settle();
    check("wbh.c7.inval", snp_inval, 0);
    check("wbh.c7.downgrade", snp_downgrade, 0);
    check("wbh.c7.cctrans", cctrans, 0);
    check("wbh.c7.dWEN", dWEN, 1);
    next(); dwait = 0; settle();
    check("wbh.c8.cctrans", cctrans, 1);
    check("wbh.c8.ccwrite", ccwrite, 0);
    check("wbh.c8.dstore", dstore, 32'h55);
    next(); settle();
    check("wbh.c9.dstore", dstore, 32'h66);
    check("wbh.c9.daddr", daddr, 32'h404);
    next(); dwait = 1; settle();
    check("wbh.c10.done", req_done, 1);
    next(); req_valid = 0; settle();

    // ---- FILL_M at 0x500 held in W0 across a missing snoop ----
    next(); req_valid = 1; req_kind = 2'd1; req_addr = 32'h500; dwait = 1; settle();
    next(); ccwait = 1; ccsnoopaddr = 32'h600; snp_hit = 0; snp_dirty = 0; settle();
    check("fm.c2.dREN", dREN, 1);
    check("fm.c2.ccwrite", ccwrite, 1);
    next(); settle();
    check("fm.c3.cctrans", cctrans, 0);
    check("fm.c3.ccwrite", ccwrite, 0);
    check("fm.c3.dREN", dREN, 1);
    next(); ccwait = 0; settle();
    next(); settle();
    check("fm.c5.downgrade", snp_downgrade, 0);
    check("fm.c5.inval", snp_inval, 0);
    check("fm.c5.dREN", dREN, 1);
    next(); dwait = 0; dload = 32'h77; settle();
    check("fm.c6.ccwrite", ccwrite, 1);
    check("fm.c6.daddr", daddr, 32'h500);
    next(); dload = 32'h88; settle();
    check("fm.c7.daddr", daddr, 32'h504);
    next(); dwait = 1; settle();
    check("fm.c8.done", req_done, 1);
    check("fm.c8.fill0", fill_data0, 32'h77);
    check("fm.c8.fill1", fill_data1, 32'h88);
    next(); req_valid = 0; settle();

    // ---- RST pulsed while in W1 ----
    next(); req_valid = 1; req_kind = 2'd0; req_addr = 32'h700; dwait = 1; settle();
    next(); dwait = 0; dload = 32'h99; settle();
    next(); dwait = 1; dload = 0; settle();
    check("rst.pre.daddr", daddr, 32'h704);
    check("rst.pre.fill0", fill_data0, 32'h99);
    #1; RST = 1; req_valid = 0; #1;
    check_quiet("rst.async");
    check("rst.async.fill0", fill_data0, 0);
    check("rst.async.fill1", fill_data1, 0);
    next(); RST = 0; dwait = 0; settle();
    check_quiet("rst.post1");
    next(); settle();
    check_quiet("rst.post2");
    next(); dwait = 1; settle();
    check("rst.post3.done", req_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
